// File: rtl/caliptra_prim_mubi_pkg.sv
// Multi-bit boolean (mubi4) encodings and strict decode helpers.
// Only the strict true/false values are valid. Every other 4-bit pattern is invalid,
// so a single bit flip cannot turn "off" into "on".
package caliptra_prim_mubi_pkg;

   typedef enum logic [3:0] {
      MuBi4True  = 4'h6,
      MuBi4False = 4'h9
   } mubi4_t;

   function automatic logic mubi4_test_true_strict(logic [3:0] val);
      return val == MuBi4True;
   endfunction

   function automatic logic mubi4_test_false_strict(logic [3:0] val);
      return val == MuBi4False;
   endfunction

   function automatic logic mubi4_test_invalid(logic [3:0] val);
      return !mubi4_test_true_strict(val) && !mubi4_test_false_strict(val);
   endfunction

endpackage

// File: rtl/entropy_src_enable_ctrl_pkg.sv
// Shared entropy_src definitions used by the enable-lifecycle controller.
// It holds the controller state encoding, which is also exposed on the debug CSR,
// and the default cycle counts.
package entropy_src_enable_ctrl_pkg;

   localparam int unsigned ClrCyclesDefault    = 2;
   localparam int unsigned DrainTimeoutDefault = 64;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StClear   = 3'd1,
      StActive  = 3'd2,
      StDrain   = 3'd3,
      StQuiesce = 3'd4,
      StRearm   = 3'd5
   } enable_ctrl_state_e;

endpackage

// File: rtl/entropy_src_enable_ctrl_if.sv
// Signal bundle between the register block / core side and entropy_src_enable_ctrl.
//   sw_enable_i      mubi4 module enable from the register block
//   delayed_enable_i high while the enable-delay pipeline is still draining
//   sha3_busy_i      conditioner processing or absorbing
//   sha3_done_i      mubi4 conditioner done pulse
//   err_clr_i        software clear of the sticky drain-timeout error
//   core_enable_o    enable to the core and the enable-delay logic
//   clr_o            datapath/FSM clear to the core
//   busy_o           controller is not idle
//   drain_timeout_o  sticky: the drain was cut short by timeout
//   mubi_err_o       one-cycle pulse: sw_enable_i is not a valid mubi4 value
//   state_o          current controller state, for the debug CSR
// The master modport drives requests; the slave modport is the controller.
interface entropy_src_enable_ctrl_if;
   logic [3:0] sw_enable_i;
   logic       delayed_enable_i;
   logic       sha3_busy_i;
   logic [3:0] sha3_done_i;
   logic       err_clr_i;
   logic       core_enable_o;
   logic       clr_o;
   logic       busy_o;
   logic       drain_timeout_o;
   logic       mubi_err_o;
   logic [2:0] state_o;

   modport master (
      output sw_enable_i, delayed_enable_i, sha3_busy_i, sha3_done_i, err_clr_i,
      input  core_enable_o, clr_o, busy_o, drain_timeout_o, mubi_err_o, state_o
   );

   modport slave (
      input  sw_enable_i, delayed_enable_i, sha3_busy_i, sha3_done_i, err_clr_i,
      output core_enable_o, clr_o, busy_o, drain_timeout_o, mubi_err_o, state_o
   );
endinterface

// File: rtl/entropy_src_enable_ctrl.sv
// Enable lifecycle sequencer for entropy_src_core.
// On enable it clears the datapath for ClrCycles cycles, then asserts core enable.
// On disable it drops core enable, then waits for the delay pipeline and SHA3 to go
// quiet, bounded by DrainTimeout. It then issues one final clear and enforces a
// one-cycle off-time before returning to idle.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset
//   ctrl_if  slave side of entropy_src_enable_ctrl_if (requests in, enable/clear/status out)
// All outputs are registered.
module entropy_src_enable_ctrl
   import entropy_src_enable_ctrl_pkg::*;
   import caliptra_prim_mubi_pkg::*;
#(
   parameter int unsigned ClrCycles    = ClrCyclesDefault,
   parameter int unsigned DrainTimeout = DrainTimeoutDefault
) (
   input logic                      clk_i,
   input logic                      rst_i,
   entropy_src_enable_ctrl_if.slave ctrl_if
);

   localparam int unsigned     TmrW      = $clog2(DrainTimeout + 1);
   localparam logic [TmrW-1:0] ClrLoad   = TmrW'(ClrCycles - 1);
   localparam logic [TmrW-1:0] DrainLoad = TmrW'(DrainTimeout - 1);

   enable_ctrl_state_e state_q, state_d;
   logic [TmrW-1:0]    tmr_q, tmr_d;

   logic core_enable_q, core_enable_d;
   logic clr_q, clr_d;
   logic busy_q, busy_d;
   logic drain_timeout_q, drain_timeout_d;
   logic mubi_err_q, mubi_err_d;

   logic en_req;
   logic drained;
   logic tmr_zero;
   logic timeout_set;

   // Any encoding other than strict true counts as a disable request.
   assign en_req   = mubi4_test_true_strict(ctrl_if.sw_enable_i);
   // A done pulse in the same cycle means the conditioner has just finished.
   assign drained  = !ctrl_if.delayed_enable_i &&
                     (!ctrl_if.sha3_busy_i || mubi4_test_true_strict(ctrl_if.sha3_done_i));
   assign tmr_zero = (tmr_q == '0);

   // State, timer and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= StIdle;
         tmr_q           <= '0;
         core_enable_q   <= 1'b0;
         clr_q           <= 1'b0;
         busy_q          <= 1'b0;
         drain_timeout_q <= 1'b0;
         mubi_err_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         tmr_q           <= tmr_d;
         core_enable_q   <= core_enable_d;
         clr_q           <= clr_d;
         busy_q          <= busy_d;
         drain_timeout_q <= drain_timeout_d;
         mubi_err_q      <= mubi_err_d;
      end
   end

   // Next state and timer. The timer only decrements on paths where it is known to be
   // non-zero, so it never wraps.
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      timeout_set = 1'b0;
      case (state_q)
         StIdle: begin
            if (en_req) begin
               state_d = StClear;
               tmr_d   = ClrLoad;
            end
         end
         StClear: begin
            // The clear always runs to completion, even if the request drops.
            if (tmr_zero) begin
               state_d = StActive;
            end else begin
               tmr_d = tmr_q - TmrW'(1);
            end
         end
         StActive: begin
            if (!en_req) begin
               state_d = StDrain;
               tmr_d   = DrainLoad;
            end
         end
         StDrain: begin
            // A clean drain takes priority over a timeout in the same cycle.
            if (drained) begin
               state_d = StQuiesce;
            end else if (tmr_zero) begin
               state_d     = StQuiesce;
               timeout_set = 1'b1;
            end else begin
               tmr_d = tmr_q - TmrW'(1);
            end
         end
         StQuiesce: state_d = StRearm;
         StRearm:   state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies line up with state_q.
   always_comb begin
      core_enable_d   = (state_d == StActive);
      clr_d           = (state_d == StClear) || (state_d == StQuiesce);
      busy_d          = (state_d != StIdle);
      // Setting the error wins over a software clear in the same cycle.
      drain_timeout_d = timeout_set || (drain_timeout_q && !ctrl_if.err_clr_i);
      mubi_err_d      = mubi4_test_invalid(ctrl_if.sw_enable_i);
   end

   assign ctrl_if.core_enable_o   = core_enable_q;
   assign ctrl_if.clr_o           = clr_q;
   assign ctrl_if.busy_o          = busy_q;
   assign ctrl_if.drain_timeout_o = drain_timeout_q;
   assign ctrl_if.mubi_err_o      = mubi_err_q;
   assign ctrl_if.state_o         = state_q;

endmodule

// File: tb/tb_entropy_src_enable_ctrl.sv
// Self-checking bench for entropy_src_enable_ctrl.
// Directed lifecycle steps are followed by randomized stimulus. Every cycle is compared
// with a phase/elapsed-cycle reference model.
module tb_entropy_src_enable_ctrl;

   localparam int unsigned ClrCycles    = 2;
   localparam int unsigned DrainTimeout = 64;
   localparam logic [3:0]  SwTrue       = 4'h6;
   localparam logic [3:0]  SwFalse      = 4'h9;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   entropy_src_enable_ctrl_if ctrl_if ();

   entropy_src_enable_ctrl #(
      .ClrCycles   (ClrCycles),
      .DrainTimeout(DrainTimeout)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .ctrl_if(ctrl_if)
   );

   int n_tests = 0;
   int n_fail  = 0;
   string phase_tag = "reset";

   // Stimulus values presented to the DUT in the next step.
   logic [3:0] sw   = SwFalse;
   logic [3:0] done = SwFalse;
   logic       de   = 1'b0;
   logic       busy = 1'b0;
   logic       eclr = 1'b0;

   // Reference model: the phase number is the documented state_o encoding.
   // m_cnt counts the cycles completed in the current phase.
   int   m_state = 0;
   int   m_cnt   = 0;
   logic m_err   = 1'b0;
   logic m_merr  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s observed=%0d expected=%0d", phase_tag, tag, obs, exp);
      end
   endtask

   task automatic step();
      logic en, drained, set;
      ctrl_if.sw_enable_i      = sw;
      ctrl_if.delayed_enable_i = de;
      ctrl_if.sha3_busy_i      = busy;
      ctrl_if.sha3_done_i      = done;
      ctrl_if.err_clr_i        = eclr;
      @(posedge clk);
      en      = (sw == SwTrue);
      drained = !de && (!busy || done == SwTrue);
      set     = 1'b0;
      if (rst) begin
         m_state = 0;
         m_cnt   = 0;
         m_err   = 1'b0;
         m_merr  = 1'b0;
      end else begin
         m_merr = (sw != SwTrue) && (sw != SwFalse);
         case (m_state)
            0: if (en) begin m_state = 1; m_cnt = 0; end
            1: begin
               m_cnt++;
               if (m_cnt == ClrCycles) m_state = 2;
            end
            2: if (!en) begin m_state = 3; m_cnt = 0; end
            3: begin
               m_cnt++;
               if (drained) m_state = 4;
               else if (m_cnt == DrainTimeout) begin m_state = 4; set = 1'b1; end
            end
            4: m_state = 5;
            default: m_state = 0;
         endcase
         if (set) m_err = 1'b1;
         else if (eclr) m_err = 1'b0;
      end
      #1;
      chk("state", ctrl_if.state_o, m_state);
      chk("clr", ctrl_if.clr_o, (m_state == 1 || m_state == 4));
      chk("core_enable", ctrl_if.core_enable_o, (m_state == 2));
      chk("busy", ctrl_if.busy_o, (m_state != 0));
      chk("drain_timeout", ctrl_if.drain_timeout_o, m_err);
      chk("mubi_err", ctrl_if.mubi_err_o, m_merr);
   endtask

   // Request enable and step until ACTIVE, bounded so that a stuck DUT cannot hang the run.
   task automatic go_active();
      sw = SwTrue;
      for (int i = 0; i < 100 && ctrl_if.state_o != 3'd2; i++) step();
      chk("reach_active", ctrl_if.state_o, 2);
   endtask

   initial begin
      int rise, clr_cnt, drain_cnt, r;

      // Reset.
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // Enable from IDLE: CLEAR for two cycles, then core enable on the third cycle.
      phase_tag = "enable";
      sw = SwTrue;
      rise = 0;
      clr_cnt = 0;
      for (int c = 1; c <= 6; c++) begin
         step();
         if (ctrl_if.clr_o) clr_cnt++;
         if (ctrl_if.core_enable_o && rise == 0) rise = c;
      end
      chk("core_en_rise_cycle", rise, 3);
      chk("clr_cycle_count", clr_cnt, 2);

      // Normal drain: delayed enable stays high for five DRAIN cycles.
      phase_tag = "drain_normal";
      sw = SwFalse;
      de = 1'b1;
      step();
      chk("core_en_drop", ctrl_if.core_enable_o, 0);
      drain_cnt = (ctrl_if.state_o == 3'd3) ? 1 : 0;
      clr_cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i > 5) de = 1'b0;
         step();
         if (ctrl_if.state_o == 3'd3) drain_cnt++;
         if (ctrl_if.clr_o) clr_cnt++;
      end
      chk("drain_len", drain_cnt, 6);
      chk("final_clr_pulses", clr_cnt, 1);
      chk("back_idle", ctrl_if.state_o, 0);

      // SHA3 stuck busy: the drain is cut short by the timeout.
      phase_tag = "drain_timeout";
      go_active();
      busy = 1'b1;
      sw = SwFalse;
      drain_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (ctrl_if.state_o == 3'd3) drain_cnt++;
      end
      chk("timeout_drain_len", drain_cnt, 64);
      chk("timeout_set", ctrl_if.drain_timeout_o, 1);
      busy = 1'b0;
      go_active();
      chk("timeout_sticky", ctrl_if.drain_timeout_o, 1);
      eclr = 1'b1;
      step();
      eclr = 1'b0;
      chk("timeout_cleared", ctrl_if.drain_timeout_o, 0);

      // Drained on the very cycle the timer expires: no error.
      phase_tag = "drain_edge";
      busy = 1'b1;
      sw = SwFalse;
      step();
      for (int i = 0; i < 63; i++) step();
      busy = 1'b0;
      step();
      chk("edge_quiesce", ctrl_if.state_o, 4);
      chk("edge_no_error", ctrl_if.drain_timeout_o, 0);
      step();
      step();

      // Invalid mubi encoding: error pulses; treated as disable.
      phase_tag = "mubi_invalid";
      sw = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("inv_err_pulse", ctrl_if.mubi_err_o, 1);
         chk("inv_stay_idle", ctrl_if.state_o, 0);
      end
      go_active();
      sw = 4'b0000;
      step();
      chk("inv_triggers_drain", ctrl_if.state_o, 3);
      sw = SwFalse;
      for (int i = 0; i < 4; i++) step();

      // Reset in the middle of a drain.
      phase_tag = "reset_mid_drain";
      go_active();
      busy = 1'b1;
      sw = SwFalse;
      for (int i = 0; i < 10; i++) step();
      sw = SwTrue;
      rst = 1'b1;
      step();
      chk("rst_state", ctrl_if.state_o, 0);
      chk("rst_no_clr", ctrl_if.clr_o, 0);
      rst = 1'b0;
      busy = 1'b0;
      step();
      chk("restart_clear", ctrl_if.state_o, 1);

      // Randomized traffic.
      phase_tag = "random";
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) begin
            r = $urandom_range(9);
            sw = (r < 4) ? SwTrue : (r < 8) ? SwFalse : 4'($urandom);
         end
         de   = ($urandom_range(3) != 0);
         busy = 1'($urandom_range(1));
         done = ($urandom_range(3) == 0) ? SwTrue : 4'($urandom);
         eclr = ($urandom_range(31) == 0);
         rst  = ($urandom_range(199) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/entropy_src_enable_ctrl.md
Name: entropy_src_enable_ctrl

Overview:
Sequences the enable lifecycle of entropy_src_core from the software enable bit.
- On enable: issues a clear of the core datapath, then asserts the core enable.
- On disable: drops the core enable, waits for the downstream delayed-enable/drain logic and the SHA3 conditioner to go quiet (bounded by a timeout), then issues a final clear.
- Sits between the register block (sw enable, error clear) and the core plus its enable-delay logic, and is the single owner of core enable and datapath clear.

Parameters:
- ClrCycles, 2, number of cycles clr_o is held high on entry to ACTIVE.
- DrainTimeout, 64, maximum cycles spent in DRAIN before forced exit; must be >= 2.
- TmrW, $clog2(DrainTimeout+1), derived width of the shared down-counter; not overridable.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- sw_enable_i  in  4  mubi4_t module enable from register block.
- delayed_enable_i  in  1  delayed enable from the enable-delay logic; high while the pipeline is draining.
- sha3_busy_i  in  1  conditioner processing or absorbing.
- sha3_done_i  in  4  mubi4_t conditioner done pulse.
- err_clr_i  in  1  software clear of the sticky timeout error.
- core_enable_o  out  1  enable to entropy_src_core and the enable-delay logic.
- clr_o  out  1  datapath/FSM clear to the core.
- busy_o  out  1  high in any state other than IDLE.
- drain_timeout_o  out  1  sticky: DRAIN exited by timeout.
- mubi_err_o  out  1  one-cycle pulse: sw_enable_i is not a valid mubi4 encoding.
- state_o  out  3  current state encoding, for debug CSR.

Behaviour:
- Reset (rst_i high at a clock edge):
  - State becomes IDLE and the timer becomes 0.
  - core_enable_o=0, clr_o=0, busy_o=0, drain_timeout_o=0, mubi_err_o=0, state_o=IDLE.
  - Applies mid-operation too: no clear pulse is issued on reset.
- en_req = mubi4_test_true_strict(sw_enable_i).
  - mubi_err_o = !mubi4_test_true_strict && !mubi4_test_false_strict, registered (1-cycle latency).
  - An invalid encoding is treated as en_req=0.
- All outputs are registered; Moore FSM. States and encodings:
  - IDLE=0, CLEAR=1, ACTIVE=2, DRAIN=3, QUIESCE=4, REARM=5.
- IDLE:
  - All outputs low.
  - en_req=1 -> CLEAR; load timer with ClrCycles-1.
- CLEAR:
  - clr_o=1, core_enable_o=0.
  - Timer==0 -> ACTIVE; otherwise decrement.
  - en_req falling during CLEAR is ignored: CLEAR always completes, then ACTIVE is entered for at least one cycle.
- ACTIVE:
  - core_enable_o=1.
  - en_req=0 -> DRAIN; load timer with DrainTimeout-1.
- DRAIN:
  - core_enable_o=0.
  - Drained when delayed_enable_i==0 && sha3_busy_i==0. A sha3_done_i true pulse in the same cycle counts as not busy.
  - Drained -> QUIESCE.
  - Else timer==0 -> QUIESCE and set drain_timeout_o.
  - Else decrement.
  - Drained has priority over timeout when both hold in the same cycle: no error is set.
  - en_req returning high during DRAIN is ignored.
- QUIESCE:
  - clr_o=1 for exactly one cycle -> REARM.
- REARM:
  - One-cycle minimum off-time -> IDLE.
  - A still-asserted en_req is acted on from IDLE on the following cycle, giving a full CLEAR/ACTIVE sequence.
- drain_timeout_o:
  - Set by timeout; cleared by err_clr_i.
  - Set wins over err_clr_i in the same cycle.
  - Not cleared by re-enable.
- Timer:
  - Single TmrW-bit down-counter shared by CLEAR and DRAIN.
  - Never wraps: the decrement is gated at 0.
- Minimum latency, en_req rising to core_enable_o=1: 1 cycle (IDLE->CLEAR) + ClrCycles cycles (CLEAR) = 3 cycles with the default ClrCycles=2.

Decomposition:
- Add to the shared entropy_src package:
  - the enable_ctrl_state_e enum (3-bit, encodings above);
  - the DrainTimeoutDefault and ClrCyclesDefault constants.
- mubi4 helpers come from caliptra_prim_mubi_pkg.
- No sub-module: the FSM, timer and error flop live in one module. The down-counter is inline.

Test Plan:
- Reset then sw_enable=MuBi4True:
  - state_o goes 0->1->1->2;
  - clr_o high for exactly 2 cycles;
  - core_enable_o rises on cycle 3 after the request;
  - busy_o=1 from cycle 1.
- Active, sw_enable=MuBi4False, delayed_enable_i high 5 cycles, sha3_busy_i low:
  - core_enable_o drops next cycle;
  - DRAIN lasts 6 cycles;
  - one clr_o pulse, then REARM, then IDLE;
  - drain_timeout_o stays 0.
- Disable with sha3_busy_i stuck high:
  - DRAIN exits after exactly 64 cycles;
  - drain_timeout_o=1 and persists through re-enable;
  - err_clr_i pulse clears it.
- Drained and timer==0 in the same cycle (drain at cycle 64): drain_timeout_o remains 0.
- sw_enable=4'b0000 (invalid):
  - mubi_err_o pulses every cycle the value is held;
  - FSM stays IDLE;
  - from ACTIVE, the invalid value triggers DRAIN.
- rst_i asserted during DRAIN with timer mid-count:
  - next cycle state_o=IDLE, all outputs 0, no clr_o pulse;
  - held sw_enable=MuBi4True then restarts at CLEAR.
